// File: rtl/sr_latch_checker.sv
// Golden gated-SR model plus settle/compare monitor for a latch under test.
// Latency: a check completes SETTLE+2 cycles after the new inputs are registered.
// Backpressure: none; a new input change simply restarts the settle window.
module sr_latch_checker #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             g_in,
  input  logic             q_in,
  input  logic             qb_in,
  output logic             model_q,
  output logic             model_valid,
  output logic             busy,
  output logic             err,
  output logic             forbidden,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  // Settle counter is loaded with SETTLE-1 so the FSM spends exactly SETTLE cycles in ST_SETTLE.
  localparam logic [7:0]       RELOAD  = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Sampled inputs, ordered {s, r, g}.
  logic [2:0] cur;
  logic [2:0] prev;
  logic       change;
  logic       mismatch;
  logic [7:0] cnt;
  state_t     state;

  assign change = (cur != prev);

  // Compare rule: with an undefined model state only a both-high output pair is illegal.
  always_comb begin
    mismatch = 1'b0;
    if (model_valid) begin
      mismatch = (q_in != model_q) || (qb_in != ~model_q);
    end else begin
      mismatch = q_in & qb_in;
    end
  end

  // Register the stimulus every cycle and keep the previous sample for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 3'b000;
      prev <= 3'b000;
    end else begin
      cur  <= {s_in, r_in, g_in};
      prev <= cur;
    end
  end

  // Golden latch: only reacts on the edge that registers a new input combination.
  always_ff @(posedge clk) begin
    if (rst) begin
      model_q     <= 1'b0;
      model_valid <= 1'b0;
      forbidden   <= 1'b0;
    end else begin
      forbidden <= 1'b0;
      if (change && cur[0]) begin
        case (cur[2:1])
          2'b10: begin
            model_q     <= 1'b1;
            model_valid <= 1'b1;
          end
          2'b01: begin
            model_q     <= 1'b0;
            model_valid <= 1'b1;
          end
          2'b11: begin
            // Q is left as it was; only its validity is withdrawn.
            model_valid <= 1'b0;
            forbidden   <= 1'b1;
          end
          default: begin
            model_q     <= model_q;
            model_valid <= model_valid;
          end
        endcase
      end
    end
  end

  // Settle/check sequencer with registered busy, err and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      busy    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      chk_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (change) begin
            cnt   <= RELOAD;
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (change) begin
            // Inputs moved again before they settled: restart the window.
            cnt <= RELOAD;
          end else if (cnt == 8'd0) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_CHECK: begin
          // The old inputs are still judged even if a new change arrives now.
          err <= mismatch;
          if (mismatch && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
          end
          if (chk_cnt != CNT_MAX) begin
            chk_cnt <= chk_cnt + CNT_ONE;
          end
          if (change) begin
            cnt   <= RELOAD;
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_checker.sv
// Bench for sr_latch_checker: directed scenarios plus random stimulus against a window-based model.
// Two instances share stimulus; the second uses CNT_W=2 to exercise counter saturation.
// Inputs change on the falling edge; outputs are judged 1 time unit after each rising edge.
module tb_sr_latch_checker;

  localparam int S    = 2;
  localparam int MAXE = 8192;

  logic clk;
  logic rst;
  logic s_d, r_d, g_d, q_d, qb_d;

  logic       model_q_a, model_valid_a, busy_a, err_a, forbidden_a;
  logic [7:0] err_cnt_a, chk_cnt_a;
  logic       model_q_b, model_valid_b, busy_b, err_b, forbidden_b;
  logic [1:0] err_cnt_b, chk_cnt_b;

  sr_latch_checker #(.SETTLE(S), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .s_in(s_d), .r_in(r_d), .g_in(g_d), .q_in(q_d), .qb_in(qb_d),
    .model_q(model_q_a), .model_valid(model_valid_a), .busy(busy_a), .err(err_a),
    .forbidden(forbidden_a), .err_cnt(err_cnt_a), .chk_cnt(chk_cnt_a)
  );

  sr_latch_checker #(.SETTLE(S), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .s_in(s_d), .r_in(r_d), .g_in(g_d), .q_in(q_d), .qb_in(qb_d),
    .model_q(model_q_b), .model_valid(model_valid_b), .busy(busy_b), .err(err_b),
    .forbidden(forbidden_b), .err_cnt(err_cnt_b), .chk_cnt(chk_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchecks = 0;
  int nerr    = 0;
  int e       = 0;
  int n_forb  = 0;
  int n_erra  = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    nchecks++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp_v);
    end
  endtask

  // History of what the DUT registered at each rising edge, indexed by edge number.
  logic [2:0] cur_h [MAXE];
  bit         chg_h [MAXE];
  bit         mq_h  [MAXE];
  bit         mv_h  [MAXE];

  // Reference: a check lands S+2 edges after a registered change, provided the
  // following S edges brought no further change and no reset intervened.
  initial begin : monitor
    logic [2:0] in_v;
    logic [2:0] pv;
    logic       rst_v, q_v, qb_v;
    bit         do_chk, mis, forb_exp, busy_exp;
    int         m, lo, last_rst, ecnt, ccnt;
    last_rst = 0;
    ecnt     = 0;
    ccnt     = 0;
    forever begin
      @(posedge clk);
      rst_v = rst;
      in_v  = {s_d, r_d, g_d};
      q_v   = q_d;
      qb_v  = qb_d;
      #1;
      if (e >= MAXE) begin
        $display("FAIL edge_budget: got %0d edges, expected below %0d", e, MAXE);
        nerr++;
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $fatal(1, "edge budget exceeded");
      end
      if (rst_v) last_rst = e;
      cur_h[e] = rst_v ? 3'b000 : in_v;
      pv       = (rst_v || e == 0) ? 3'b000 : cur_h[e-1];
      chg_h[e] = (cur_h[e] != pv);

      // Latch state implied by the input history.
      if (rst_v || e == 0) begin
        mq_h[e] = 1'b0;
        mv_h[e] = 1'b0;
      end else begin
        mq_h[e] = mq_h[e-1];
        mv_h[e] = mv_h[e-1];
        if (chg_h[e-1] && cur_h[e-1][0]) begin
          if (cur_h[e-1][2:1] == 2'b10) begin
            mq_h[e] = 1'b1;
            mv_h[e] = 1'b1;
          end else if (cur_h[e-1][2:1] == 2'b01) begin
            mq_h[e] = 1'b0;
            mv_h[e] = 1'b1;
          end else if (cur_h[e-1][2:1] == 2'b11) begin
            mv_h[e] = 1'b0;
          end
        end
      end

      forb_exp = !rst_v && e > 0 && chg_h[e-1] && (cur_h[e-1] == 3'b111);

      m      = e - S - 2;
      do_chk = 1'b0;
      if (!rst_v && m >= 0 && m >= last_rst && chg_h[m]) begin
        do_chk = 1'b1;
        for (int j = 1; j <= S; j++) if (chg_h[m+j]) do_chk = 1'b0;
      end

      mis = 1'b0;
      if (do_chk) begin
        if (mv_h[e-1]) mis = (q_v != mq_h[e-1]) || (qb_v != !mq_h[e-1]);
        else           mis = q_v && qb_v;
      end

      if (rst_v) begin
        ecnt = 0;
        ccnt = 0;
      end else if (do_chk) begin
        ccnt++;
        if (mis) ecnt++;
      end

      busy_exp = 1'b0;
      lo = (e - S - 1 > last_rst) ? e - S - 1 : last_rst;
      if (!rst_v) for (int k = lo; k < e; k++) if (chg_h[k]) busy_exp = 1'b1;

      chk("model_q",       int'(model_q_a),     int'(mq_h[e]));
      chk("model_valid",   int'(model_valid_a), int'(mv_h[e]));
      chk("busy",          int'(busy_a),        int'(busy_exp));
      chk("err",           int'(err_a),         int'(do_chk && mis));
      chk("forbidden",     int'(forbidden_a),   int'(forb_exp));
      chk("err_cnt",       int'(err_cnt_a),     (ecnt > 255) ? 255 : ecnt);
      chk("chk_cnt",       int'(chk_cnt_a),     (ccnt > 255) ? 255 : ccnt);
      chk("b_model_q",     int'(model_q_b),     int'(mq_h[e]));
      chk("b_model_valid", int'(model_valid_b), int'(mv_h[e]));
      chk("b_busy",        int'(busy_b),        int'(busy_exp));
      chk("b_err",         int'(err_b),         int'(do_chk && mis));
      chk("b_forbidden",   int'(forbidden_b),   int'(forb_exp));
      chk("b_err_cnt",     int'(err_cnt_b),     (ecnt > 3) ? 3 : ecnt);
      chk("b_chk_cnt",     int'(chk_cnt_b),     (ccnt > 3) ? 3 : ccnt);

      n_forb += int'(forbidden_a);
      n_erra += int'(err_a);
      e++;
    end
  end

  // Latch under test as seen by the checker: 0 = correct gated SR latch,
  // 1 = Q stuck at 0, 2 = random Q/Qb.
  int mode;
  bit lq;

  task automatic apply(input logic [2:0] v);
    {s_d, r_d, g_d} = v;
    if (v[0] && v[2:1] == 2'b10) lq = 1'b1;
    if (v[0] && v[2:1] == 2'b01) lq = 1'b0;
    case (mode)
      0: begin
        q_d  = (v == 3'b111) ? 1'b0 : lq;
        qb_d = (v == 3'b111) ? 1'b0 : !lq;
      end
      1: begin
        q_d  = 1'b0;
        qb_d = (v == 3'b111) ? 1'b0 : !lq;
      end
      default: begin
        q_d  = 1'($urandom);
        qb_d = 1'($urandom);
      end
    endcase
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    lq  = 1'b0;
    apply(3'b000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    int f0, e0, n;
    logic [2:0] v;
    rst  = 1'b1;
    mode = 0;
    lq   = 1'b0;
    apply(3'b000);
    hold(3);
    rst = 1'b0;

    // Quiet after reset.
    hold(20);
    chk("idle_busy",        int'(busy_a),        0);
    chk("idle_err",         int'(err_a),         0);
    chk("idle_chk_cnt",     int'(chk_cnt_a),     0);
    chk("idle_model_valid", int'(model_valid_a), 0);

    // Set with a correct latch: the check lands four edges after registration.
    apply(3'b101);
    repeat (4) @(posedge clk);
    #2;
    chk("set_chk_cnt_early", int'(chk_cnt_a), 0);
    @(posedge clk);
    #2;
    chk("set_chk_cnt",     int'(chk_cnt_a),     1);
    chk("set_model_q",     int'(model_q_a),     1);
    chk("set_model_valid", int'(model_valid_a), 1);
    chk("set_err_cnt",     int'(err_cnt_a),     0);

    // Sweep all input combinations against a correct latch.
    do_reset();
    f0 = n_forb;
    for (int i = 0; i < 8; i++) begin
      apply(3'(i));
      hold(10);
    end
    chk("sweep_chk_cnt",     int'(chk_cnt_a),     7);
    chk("sweep_err_cnt",     int'(err_cnt_a),     0);
    chk("sweep_forbidden",   n_forb - f0,         1);
    chk("sweep_model_valid", int'(model_valid_a), 0);

    // Q stuck at 0: a single err pulse exactly four edges after registration.
    do_reset();
    mode = 1;
    e0 = n_erra;
    apply(3'b101);
    repeat (4) @(posedge clk);
    #2;
    chk("stuck_err_before", int'(err_a), 0);
    @(posedge clk);
    #2;
    chk("stuck_err_pulse", int'(err_a), 1);
    @(posedge clk);
    #2;
    chk("stuck_err_after", int'(err_a),     0);
    chk("stuck_err_cnt",   int'(err_cnt_a), 1);
    hold(5);
    chk("stuck_err_pulses", n_erra - e0, 1);

    // Gate toggling every cycle: no check until the inputs settle.
    do_reset();
    mode = 0;
    for (int i = 0; i < 10; i++) begin
      apply({2'b10, (i % 2 == 0)});
      @(negedge clk);
    end
    chk("toggle_no_check", int'(chk_cnt_a), 0);
    chk("toggle_busy",     int'(busy_a),    1);
    hold(10);
    chk("toggle_one_check", int'(chk_cnt_a), 1);
    chk("toggle_err_cnt",   int'(err_cnt_a), 0);

    // Five mismatching checks: 2-bit counters pin at 3.
    do_reset();
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      apply((i % 2 == 1) ? 3'b001 : 3'b101);
      hold(10);
    end
    chk("sat_err_cnt_a", int'(err_cnt_a), 5);
    chk("sat_err_cnt_b", int'(err_cnt_b), 3);
    chk("sat_chk_cnt_b", int'(chk_cnt_b), 3);

    // Reset while settling discards the pending check.
    apply(3'b100);
    hold(2);
    chk("mid_busy", int'(busy_a), 1);
    rst = 1'b1;
    apply(3'b000);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",        int'(busy_a),        0);
    chk("rst_err",         int'(err_a),         0);
    chk("rst_forbidden",   int'(forbidden_a),   0);
    chk("rst_model_q",     int'(model_q_a),     0);
    chk("rst_model_valid", int'(model_valid_a), 0);
    chk("rst_err_cnt_a",   int'(err_cnt_a),     0);
    chk("rst_err_cnt_b",   int'(err_cnt_b),     0);
    chk("rst_chk_cnt_b",   int'(chk_cnt_b),     0);
    e0 = n_erra;
    hold(10);
    chk("rst_no_err",      n_erra - e0,      0);
    chk("rst_no_check",    int'(chk_cnt_a),  0);

    // Random stimulus with occasional resets and random latch behaviour.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      mode = $urandom_range(0, 2);
      v    = 3'($urandom);
      apply(v);
      n = $urandom_range(1, 6);
      repeat (n) begin
        @(negedge clk);
        if (mode == 2) apply(v);
      end
    end
    hold(10);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
